// File: rtl/sfp_acc_pkg.sv
// Shared parameters and state encoding for the SFP accumulator.
// This package is imported by the top and by the lane adder.
package sfp_acc_pkg;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int LEN_KIJ = 9;

  localparam int          CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/sat_add_lane.sv
// One-lane signed saturating adder.
// The overflow flag reports whether the sum was clamped.
module sat_add_lane
  import sfp_acc_pkg::*;
#(
  parameter int psum_bw = PSUM_BW
) (
  input  logic signed [psum_bw-1:0] a,
  input  logic signed [psum_bw-1:0] b,
  output logic signed [psum_bw-1:0] sum,
  output logic                      ovf
);

  logic signed [psum_bw:0] full;

  always_comb begin
    full = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    ovf  = full[psum_bw] != full[psum_bw-1];
    if (!ovf)
      sum = full[psum_bw-1:0];
    else if (full[psum_bw])
      sum = {1'b1, {(psum_bw-1){1'b0}}};
    else
      sum = {1'b0, {(psum_bw-1){1'b1}}};
  end

endmodule

// File: rtl/sfp_acc.sv
// Per-pixel partial-sum accumulator with optional ReLU. It emits one result
// pulse per run of acc cycles and flags short or long runs and saturation.
module sfp_acc
  import sfp_acc_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int len_kij = LEN_KIJ
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     acc,
  input  logic                     clr,
  input  logic                     relu_en,
  input  logic [col*psum_bw-1:0]   data_in,
  output logic [col*psum_bw-1:0]   sfp_out,
  output logic                     out_valid,
  output logic                     cnt_err,
  output logic                     sat
);

  logic [1:0]             state_q;
  logic [col*psum_bw-1:0] acc_q;
  logic [col*psum_bw-1:0] sum_all;
  logic [col*psum_bw-1:0] relu_res;
  logic [col-1:0]         ovf;
  logic [CNT_W-1:0]       cnt_q;
  logic                   sat_run_q;

  for (genvar k = 0; k < col; k++) begin : g_lane
    sat_add_lane #(.psum_bw(psum_bw)) u_lane (
      .a   (acc_q[k*psum_bw +: psum_bw]),
      .b   (data_in[k*psum_bw +: psum_bw]),
      .sum (sum_all[k*psum_bw +: psum_bw]),
      .ovf (ovf[k])
    );
  end

  always_comb begin
    relu_res = acc_q;
    if (relu_en) begin
      for (int unsigned k = 0; k < col; k++) begin
        if (acc_q[k*psum_bw + psum_bw - 1])
          relu_res[k*psum_bw +: psum_bw] = '0;
      end
    end
  end

  // The running sat flag is private; the sat port only updates at completion
  // so it holds the previous pixel's status while a new pixel accumulates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_run_q <= 1'b0;
      sfp_out   <= '0;
      out_valid <= 1'b0;
      cnt_err   <= 1'b0;
      sat       <= 1'b0;
    end else if (clr) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_run_q <= 1'b0;
      sfp_out   <= '0;
      out_valid <= 1'b0;
      cnt_err   <= 1'b0;
      sat       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (acc) begin
            acc_q     <= data_in;
            cnt_q     <= CNT_W'(1);
            sat_run_q <= 1'b0;
            state_q   <= ST_ACCUM;
          end else begin
            state_q   <= ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (acc) begin
            acc_q     <= sum_all;
            sat_run_q <= sat_run_q | (|ovf);
            if (cnt_q != CNT_MAX)
              cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            sfp_out   <= relu_res;
            out_valid <= 1'b1;
            cnt_err   <= (int'(cnt_q) != len_kij);
            sat       <= sat_run_q;
            state_q   <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfp_acc.sv
// Randomized self-checking bench for sfp_acc with an arithmetic reference model.
module tb_sfp_acc;

  localparam int C = 8;
  localparam int W = 16;
  localparam int L = 9;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           acc = 1'b0;
  logic           clr = 1'b0;
  logic           relu_en = 1'b0;
  logic [C*W-1:0] data_in = '0;
  logic [C*W-1:0] sfp_out;
  logic           out_valid;
  logic           cnt_err;
  logic           sat;

  int tests = 0;
  int fails = 0;

  logic signed [W-1:0] terms [0:31][0:C-1];

  sfp_acc #(.col(C), .psum_bw(W), .len_kij(L)) dut (
    .clk(clk), .reset(reset), .acc(acc), .clr(clr), .relu_en(relu_en),
    .data_in(data_in), .sfp_out(sfp_out), .out_valid(out_valid),
    .cnt_err(cnt_err), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: sequential clamped sums per lane, ReLU, count compared to L.
  task automatic model(input int n, input bit relu, output logic [C*W-1:0] eo,
                       output logic ee, output logic es);
    int s;
    int cnt;
    es = 1'b0;
    eo = '0;
    for (int k = 0; k < C; k++) begin
      s = int'(terms[0][k]);
      for (int i = 1; i < n; i++) begin
        s = s + int'(terms[i][k]);
        if (s > 32767) begin s = 32767; es = 1'b1; end
        if (s < -32768) begin s = -32768; es = 1'b1; end
      end
      if (relu && s < 0) s = 0;
      eo[k*W +: W] = W'(s);
    end
    cnt = (n > 15) ? 15 : n;
    ee = (cnt != L);
  endtask

  // Drives n acc cycles from terms[], then one completion cycle; relu_en is
  // inverted during accumulation so only the completion-cycle value matters.
  task automatic drive_pixel(input int n, input bit relu, output logic [C*W-1:0] o,
                             output logic v, output logic e, output logic s,
                             output int early);
    early = 0;
    for (int i = 0; i < n; i++) begin
      acc = 1'b1;
      relu_en = ~relu;
      for (int k = 0; k < C; k++) data_in[k*W +: W] = terms[i][k];
      step();
      if (out_valid) early++;
    end
    acc = 1'b0;
    relu_en = relu;
    data_in = {$urandom, $urandom, $urandom, $urandom};
    step();
    o = sfp_out; v = out_valid; e = cnt_err; s = sat;
  endtask

  task automatic fill(input int n, input int lane_val);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < C; k++) terms[i][k] = W'(lane_val);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    step(); step();
    tests++;
    if ({sfp_out, out_valid, cnt_err, sat} !== '0) begin
      fails++;
      $display("FAIL reset_state got out=%h v=%b e=%b s=%b exp all 0", sfp_out, out_valid, cnt_err, sat);
    end
    reset = 1'b1;
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_release_valid got %b exp 0", out_valid);
    end
  endtask

  task automatic test_basic;
    logic [C*W-1:0] o, eo; logic v, e, s, ee, es; int early;
    fill(9, 2);
    model(9, 1'b0, eo, ee, es);
    drive_pixel(9, 1'b0, o, v, e, s, early);
    tests++;
    if (early != 0 || v !== 1'b1) begin
      fails++; $display("FAIL basic_valid got early=%0d v=%b exp early=0 v=1", early, v);
    end
    tests++;
    if (o !== eo || o !== {C{16'h0012}}) begin
      fails++; $display("FAIL basic_out got %h exp %h", o, eo);
    end
    tests++;
    if (e !== 1'b0 || s !== 1'b0) begin
      fails++; $display("FAIL basic_flags got e=%b s=%b exp e=0 s=0", e, s);
    end
    step();
    tests++;
    if (out_valid !== 1'b0 || sfp_out !== eo) begin
      fails++; $display("FAIL basic_hold got v=%b out=%h exp v=0 out=%h", out_valid, sfp_out, eo);
    end
  endtask

  task automatic test_relu;
    logic [C*W-1:0] o, eo; logic v, e, s, ee, es; int early;
    fill(9, 0);
    for (int i = 0; i < 9; i++) terms[i][0] = -16'sd5;
    drive_pixel(9, 1'b1, o, v, e, s, early);
    tests++;
    if (o[15:0] !== 16'h0000 || v !== 1'b1) begin
      fails++; $display("FAIL relu_on_lane0 got %h v=%b exp 0000 v=1", o[15:0], v);
    end
    step();
    model(9, 1'b0, eo, ee, es);
    drive_pixel(9, 1'b0, o, v, e, s, early);
    tests++;
    if (o[15:0] !== 16'hFFD3 || o !== eo) begin
      fails++; $display("FAIL relu_off_lane0 got %h exp ffd3 (full %h exp %h)", o[15:0], o, eo);
    end
    step();
  endtask

  task automatic test_saturation;
    logic [C*W-1:0] o; logic v, e, s; int early;
    fill(9, 0);
    terms[0][3] = 16'sh7000; terms[1][3] = 16'sh2000;
    drive_pixel(9, 1'b0, o, v, e, s, early);
    tests++;
    if (o[3*W +: W] !== 16'h7FFF || s !== 1'b1 || o[2*W +: W] !== 16'h0000) begin
      fails++; $display("FAIL sat_pos got lane3=%h sat=%b exp 7fff sat=1", o[3*W +: W], s);
    end
    step();
    fill(9, 0);
    terms[0][3] = 16'sh9000; terms[1][3] = -16'sh2000; terms[2][3] = -16'sh0100;
    drive_pixel(9, 1'b0, o, v, e, s, early);
    tests++;
    if (o[3*W +: W] !== 16'h8000 || s !== 1'b1) begin
      fails++; $display("FAIL sat_neg got lane3=%h sat=%b exp 8000 sat=1", o[3*W +: W], s);
    end
    step();
  endtask

  task automatic test_back_to_back;
    logic [C*W-1:0] o, eo; logic v, e, s, ee, es; int early;
    fill(8, 3);
    drive_pixel(8, 1'b0, o, v, e, s, early);
    tests++;
    if (e !== 1'b1 || v !== 1'b1 || o !== {C{16'h0018}}) begin
      fails++; $display("FAIL short_run got e=%b v=%b out=%h exp e=1 v=1", e, v, o);
    end
    fill(9, 7);
    model(9, 1'b0, eo, ee, es);
    drive_pixel(9, 1'b0, o, v, e, s, early);
    tests++;
    if (e !== 1'b0 || v !== 1'b1 || o !== eo || early != 0) begin
      fails++; $display("FAIL b2b_run got e=%b v=%b out=%h early=%0d exp e=0 v=1 out=%h", e, v, o, early, eo);
    end
    step();
  endtask

  task automatic test_reset_abort;
    logic [C*W-1:0] o; logic v, e, s; int early; int seen;
    fill(9, 1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      acc = 1'b1;
      for (int k = 0; k < C; k++) data_in[k*W +: W] = terms[i][k];
      step();
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({sfp_out, out_valid, cnt_err, sat} !== '0) begin
      fails++; $display("FAIL async_reset got out=%h v=%b exp 0", sfp_out, out_valid);
    end
    acc = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); if (out_valid) seen++; end
    drive_pixel(9, 1'b0, o, v, e, s, early);
    tests++;
    if (seen != 0 || early != 0 || o !== {C{16'h0009}} || v !== 1'b1 || e !== 1'b0) begin
      fails++; $display("FAIL reset_abort got seen=%0d early=%0d out=%h v=%b e=%b exp 0 0 all 0009 1 0",
                        seen, early, o, v, e);
    end
    step();
  endtask

  task automatic test_clr;
    fill(4, 5);
    for (int i = 0; i < 4; i++) begin
      acc = 1'b1;
      for (int k = 0; k < C; k++) data_in[k*W +: W] = terms[i][k];
      step();
    end
    clr = 1'b1;
    step();
    tests++;
    if ({sfp_out, out_valid, cnt_err, sat} !== '0) begin
      fails++; $display("FAIL clr_outputs got out=%h v=%b e=%b s=%b exp 0", sfp_out, out_valid, cnt_err, sat);
    end
    clr = 1'b0;
    acc = 1'b0;
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL clr_idle got v=%b exp 0", out_valid);
    end
  endtask

  task automatic test_random;
    logic [C*W-1:0] o, eo; logic v, e, s, ee, es; int early; int n; bit relu;
    for (int p = 0; p < 25; p++) begin
      n = $urandom_range(18, 1);
      relu = 1'($urandom_range(1, 0));
      for (int i = 0; i < n; i++)
        for (int k = 0; k < C; k++)
          terms[i][k] = ($urandom_range(3, 0) == 0) ? W'($urandom) : W'($urandom_range(400, 0)) - 16'sd200;
      model(n, relu, eo, ee, es);
      drive_pixel(n, relu, o, v, e, s, early);
      tests++;
      if (o !== eo || v !== 1'b1 || e !== ee || s !== es || early != 0) begin
        fails++;
        $display("FAIL random_pixel%0d got out=%h v=%b e=%b s=%b early=%0d exp out=%h v=1 e=%b s=%b",
                 p, o, v, e, s, early, eo, ee, es);
      end
      if ($urandom_range(1, 0) == 1) step();
    end
    acc = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_back_to_back();
    test_reset_abort();
    test_clr();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
